// File: rtl/exec_alu_div_unit_if.sv
// rtl/exec_alu_div_unit_if.sv - execute-stage operand, flag and stall bundle
// The master drives operands and controls; the slave (execute unit) returns results.
interface exec_alu_div_unit_if #(parameter int WIDTH = 64);
  logic             ALUSrc;
  logic             dOrImm;
  logic [2:0]       ALUOp;
  logic [8:0]       dAddr9;
  logic [11:0]      imm12;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] ReadData2;
  logic             saveCond;
  logic             div;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  logic [3:0]       flags;
  logic             stall;

  modport master (
    output ALUSrc, dOrImm, ALUOp, dAddr9, imm12, A, ReadData2, saveCond, div,
    input  result, negative, zero, overflow, carry_out, flags, stall
  );

  modport slave (
    input  ALUSrc, dOrImm, ALUOp, dAddr9, imm12, A, ReadData2, saveCond, div,
    output result, negative, zero, overflow, carry_out, flags, stall
  );
endinterface

// File: rtl/exec_alu_div_unit.sv
// rtl/exec_alu_div_unit.sv - execute-stage ALU, condition-flag register and stalling divider
// Combinational ALU/flags; restoring unsigned divider producing one quotient bit per cycle.
module exec_alu_div_unit #(
  parameter int WIDTH      = 64,
  parameter int DIV_CYCLES = WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  exec_alu_div_unit_if.slave  bus
);
  localparam int CW = $clog2(DIV_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;

  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] addB;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] aluResult;
  logic             isAdd;
  logic             isSub;
  logic [3:0]       flagReg;

  divState_t        state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   diff;
  logic             qBit;

  always_comb begin
    if (!bus.ALUSrc)
      opB = bus.ReadData2;
    else if (bus.dOrImm)
      opB = {{(WIDTH-12){1'b0}}, bus.imm12};
    else
      opB = {{(WIDTH-9){bus.dAddr9[8]}}, bus.dAddr9};
  end

  assign isAdd = (bus.ALUOp == 3'b010);
  assign isSub = (bus.ALUOp == 3'b011);

  // Subtract reuses the adder as A + ~B + 1 so carry means "no borrow".
  assign addB = isSub ? ~opB : opB;
  assign sum  = {1'b0, bus.A} + {1'b0, addB} + (WIDTH+1)'(isSub);

  always_comb begin
    aluResult = '0;
    case (bus.ALUOp)
      3'b000:         aluResult = opB;
      3'b010, 3'b011: aluResult = sum[WIDTH-1:0];
      3'b100:         aluResult = bus.A & opB;
      3'b101:         aluResult = bus.A | opB;
      3'b110:         aluResult = bus.A ^ opB;
      default:        aluResult = '0;
    endcase
  end

  assign bus.negative  = aluResult[WIDTH-1];
  assign bus.zero      = (aluResult == '0);
  assign bus.carry_out = (isAdd | isSub) & sum[WIDTH];
  assign bus.overflow  = (isAdd | isSub) & (bus.A[WIDTH-1] == addB[WIDTH-1])
                         & (sum[WIDTH-1] != bus.A[WIDTH-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      flagReg <= 4'b0000;
    else if (bus.saveCond)
      flagReg <= {bus.carry_out, bus.overflow, bus.zero, bus.negative};
  end

  assign bus.flags = flagReg;

  // Restoring step: the borrow of the trial subtract decides the quotient bit.
  // A zero divisor never borrows, so the quotient naturally saturates to all-ones.
  assign remShift = {rem, dividend[WIDTH-1]};
  assign diff     = remShift - {1'b0, divisor};
  assign qBit     = ~diff[WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      dividend <= '0;
      divisor  <= '0;
      rem      <= '0;
      quotient <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.div) begin
            dividend <= bus.A;
            divisor  <= bus.ReadData2;
            rem      <= '0;
            count    <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          rem      <= qBit ? diff[WIDTH-1:0] : remShift[WIDTH-1:0];
          dividend <= {dividend[WIDTH-2:0], qBit};
          count    <= count + CW'(1);
          if (count == CW'(DIV_CYCLES - 1)) begin
            quotient <= {dividend[WIDTH-2:0], qBit};
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by reset so an in-flight divide releases the pipeline immediately.
  assign bus.stall  = ~reset & (((state == IDLE) & bus.div) | (state == BUSY));
  assign bus.result = bus.div ? quotient : aluResult;
endmodule

// File: tb/tb_exec_alu_div_unit.sv
// tb/tb_exec_alu_div_unit.sv - self-checking bench for exec_alu_div_unit
// Directed vectors with literal expectations plus a per-cycle behavioural model compare.
module tb_exec_alu_div_unit;
  logic clk;
  logic reset;
  int   nChecks;
  int   nFails;
  logic [3:0] mFlags;

  exec_alu_div_unit_if #(.WIDTH(64)) bus ();

  exec_alu_div_unit #(.WIDTH(64), .DIV_CYCLES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {C, V, Z, N, result} from the arithmetic meaning of each opcode.
  function automatic logic [67:0] aluModel(input logic src, input logic dI, input logic [2:0] op,
                                           input logic [8:0] d9, input logic [11:0] i12,
                                           input logic [63:0] a, input logic [63:0] rd2);
    logic [63:0] b, r;
    logic c, v;
    logic signed [63:0] d9x;
    logic signed [64:0] s;
    d9x = $signed(d9);
    b = !src ? rd2 : (dI ? {52'd0, i12} : d9x);
    c = 1'b0;
    v = 1'b0;
    s = '0;
    case (op)
      3'd0: r = b;
      3'd2: begin
        {c, r} = {1'b0, a} + {1'b0, b};
        s = $signed({a[63], a}) + $signed({b[63], b});
        v = (s[64] != s[63]);
      end
      3'd3: begin
        r = a - b;
        c = (a >= b);
        s = $signed({a[63], a}) - $signed({b[63], b});
        v = (s[64] != s[63]);
      end
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = '0;
    endcase
    return {c, v, (r == 64'd0), r[63], r};
  endfunction

  function automatic logic [63:0] divModel(input logic [63:0] a, input logic [63:0] b);
    return (b == 64'd0) ? {64{1'b1}} : a / b;
  endfunction

  function automatic logic [67:0] curModel();
    return aluModel(bus.ALUSrc, bus.dOrImm, bus.ALUOp, bus.dAddr9, bus.imm12, bus.A, bus.ReadData2);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset)
      mFlags = 4'b0000;
    else if (bus.saveCond)
      mFlags = curModel() >> 64;
  end

  always @(negedge clk) begin
    logic [67:0] m;
    m = curModel();
    chk("model flag register", {60'd0, bus.flags}, {60'd0, mFlags});
    chk("model NZVC", {60'd0, bus.carry_out, bus.overflow, bus.zero, bus.negative}, {60'd0, m[67:64]});
    if (!bus.div) begin
      chk("model result", bus.result, m[63:0]);
      chk("model stall idle", {63'd0, bus.stall}, 64'd0);
    end
  end

  task automatic runVec(input logic src, input logic dI, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] rd2, input logic [11:0] i12, input logic [8:0] d9,
                        input logic save, input logic [63:0] expRes, input logic [3:0] expF);
    @(posedge clk);
    #1;
    bus.ALUSrc = src; bus.dOrImm = dI; bus.ALUOp = op; bus.A = a; bus.ReadData2 = rd2;
    bus.imm12 = i12; bus.dAddr9 = d9; bus.saveCond = save; bus.div = 1'b0;
    #2;
    chk("vec result", bus.result, expRes);
    chk("vec CVZN", {60'd0, bus.carry_out, bus.overflow, bus.zero, bus.negative}, {60'd0, expF});
  endtask

  task automatic doDiv(input logic [63:0] a, input logic [63:0] b, input logic [63:0] expQ, input bit hold);
    int cnt;
    cnt = 0;
    @(posedge clk);
    #1;
    bus.ALUSrc = 1'b0; bus.ALUOp = 3'b010; bus.A = a; bus.ReadData2 = b;
    bus.saveCond = 1'b0; bus.div = 1'b1;
    @(negedge clk);
    chk("div start stall", {63'd0, bus.stall}, 64'd1);
    while (bus.stall && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    chk("div stall cycles", 64'(cnt), 64'd65);
    chk("div quotient literal", bus.result, expQ);
    chk("div quotient model", bus.result, divModel(a, b));
    if (!hold) begin
      @(posedge clk);
      #1;
      bus.div = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    nChecks = 0;
    nFails  = 0;
    mFlags  = 4'b0000;
    reset   = 1'b1;
    bus.ALUSrc = 1'b0; bus.dOrImm = 1'b0; bus.ALUOp = 3'b000; bus.dAddr9 = '0; bus.imm12 = '0;
    bus.A = '0; bus.ReadData2 = '0; bus.saveCond = 1'b0; bus.div = 1'b0;
    #12;
    chk("reset flags", {60'd0, bus.flags}, 64'd0);
    chk("reset stall", {63'd0, bus.stall}, 64'd0);
    chk("reset result", bus.result, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    runVec(1, 1, 3'b010, 64'd5, 64'd0, 12'hFFF, 9'h000, 0, 64'h1004, 4'b0000);
    runVec(1, 0, 3'b010, 64'd8, 64'd0, 12'h000, 9'h1F8, 0, 64'd0, 4'b1010);
    runVec(0, 0, 3'b100, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 12'h0, 9'h0, 0,
           64'hF000_F000_F000_F000, 4'b0001);
    runVec(0, 0, 3'b101, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 12'h0, 9'h0, 0,
           64'hFFFF_FFFF_FFFF_FFFF, 4'b0001);
    runVec(0, 0, 3'b110, 64'd1234, 64'd1234, 12'h0, 9'h0, 0, 64'd0, 4'b0010);
    runVec(1, 0, 3'b000, 64'd77, 64'd0, 12'h0, 9'h100, 0, 64'hFFFF_FFFF_FFFF_FF00, 4'b0001);
    runVec(0, 0, 3'b001, 64'd5, 64'd7, 12'h0, 9'h0, 0, 64'd0, 4'b0010);
    runVec(0, 0, 3'b111, 64'd5, 64'd7, 12'h0, 9'h0, 0, 64'd0, 4'b0010);
    runVec(0, 0, 3'b011, 64'd3, 64'd5, 12'h0, 9'h0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0001);
    runVec(0, 0, 3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 12'h0, 9'h0, 0, 64'h8000_0000_0000_0000, 4'b0101);
    runVec(1, 1, 3'b011, 64'd5, 64'd0, 12'h005, 9'h0, 0, 64'd0, 4'b1010);
    runVec(0, 0, 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 12'h0, 9'h0, 0,
           64'hFFFF_FFFF_FFFF_FFFE, 4'b1001);

    // Flag register: capture, hold, then asynchronous clear.
    runVec(0, 0, 3'b011, 64'h8000_0000_0000_0000, 64'd1, 12'h0, 9'h0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100);
    @(posedge clk);
    #1;
    bus.saveCond = 1'b0;
    chk("flags captured", {60'd0, bus.flags}, 64'b1100);
    runVec(1, 0, 3'b010, 64'd8, 64'd0, 12'h000, 9'h1F8, 0, 64'd0, 4'b1010);
    @(posedge clk);
    #1;
    chk("flags held", {60'd0, bus.flags}, 64'b1100);
    #2;
    reset = 1'b1;
    #1;
    chk("flags async reset", {60'd0, bus.flags}, 64'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    doDiv(64'd100, 64'd7, 64'd14, 1);
    doDiv(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    doDiv(64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    doDiv(64'hDEAD_BEEF_1234_5678, 64'h1_0000, 64'h0000_DEAD_BEEF_1234, 0);

    // Reset in the middle of a divide.
    @(posedge clk);
    #1;
    bus.ALUSrc = 1'b0; bus.A = 64'd1000; bus.ReadData2 = 64'd3; bus.div = 1'b1;
    repeat (31) @(posedge clk);
    #2;
    chk("busy stall", {63'd0, bus.stall}, 64'd1);
    reset = 1'b1;
    #1;
    chk("reset drops stall", {63'd0, bus.stall}, 64'd0);
    chk("reset clears quotient", bus.result, 64'd0);
    @(negedge clk);
    #1;
    reset   = 1'b0;
    bus.div = 1'b0;
    doDiv(64'd1000, 64'd3, 64'd333, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
